// File: rtl/id_ex_register.sv
// id_ex_register: ID/EX pipeline register with load-use bubble insertion, hold and kill.
// Optional macro ID_EX_PERF_EN adds the bubble_cnt load-use bubble counter.
module id_ex_register #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [8:0]        id_ctrl,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    output logic              ex_valid,
    output logic [8:0]        ex_ctrl,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic              load_use_stall
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]       bubble_cnt
`endif
);
    localparam int MEM_READ = 7;

    logic              r_valid;
    logic [8:0]        r_ctrl;
    logic [DATA_W-1:0] r_pc4, r_rs_data, r_rt_data, r_imm;
    logic [REG_W-1:0]  r_rs, r_rt, r_rd;
    logic              w_load_use, w_bubble;

    assign w_load_use = r_valid & r_ctrl[MEM_READ] & (r_rt != '0) & id_valid &
                        ((r_rt == id_rs) | (r_rt == id_rt));
    // a load-use bubble waits for stall to drop; flush always wins
    assign w_bubble = flush | (~stall & w_load_use);

    always_ff @(posedge clk or posedge reset) begin
        if (reset || w_bubble) begin
            r_valid   <= 1'b0;
            r_ctrl    <= '0;
            r_pc4     <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_rd      <= '0;
        end else if (!stall) begin
            r_valid   <= id_valid;
            r_ctrl    <= id_valid ? id_ctrl : 9'd0;
            r_pc4     <= id_pc4;
            r_rs_data <= id_rs_data;
            r_rt_data <= id_rt_data;
            r_imm     <= id_imm;
            r_rs      <= id_rs;
            r_rt      <= id_rt;
            r_rd      <= id_rd;
        end
    end

`ifdef ID_EX_PERF_EN
    logic [31:0] r_bubble_cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_bubble_cnt <= '0;
        else if (!flush && !stall && w_load_use)
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
    assign bubble_cnt = r_bubble_cnt;
`endif

    assign ex_valid       = r_valid;
    assign ex_ctrl        = r_ctrl;
    assign ex_pc4         = r_pc4;
    assign ex_rs_data     = r_rs_data;
    assign ex_rt_data     = r_rt_data;
    assign ex_imm         = r_imm;
    assign ex_rs          = r_rs;
    assign ex_rt          = r_rt;
    assign ex_rd          = r_rd;
    assign load_use_stall = w_load_use;
endmodule

// File: tb/tb_id_ex_register.sv
// tb_id_ex_register: scoreboard bench for id_ex_register; define ID_EX_PERF_EN to also check bubble_cnt.
module tb_id_ex_register;
    typedef struct packed {
        logic        v;
        logic [8:0]  c;
        logic [31:0] pc, rsd, rtd, imm;
        logic [4:0]  rs, rt, rd;
    } vec_t;

    typedef struct {
        string       name;
        int          due;
        bit          is_lus;
        logic        lus;
        vec_t        e;
        logic [31:0] bc;
    } exp_t;

    logic        clk = 1'b0, reset = 1'b1, stall = 1'b0, flush = 1'b0, id_valid = 1'b0;
    logic [8:0]  id_ctrl = '0;
    logic [31:0] id_pc4 = '0, id_rs_data = '0, id_rt_data = '0, id_imm = '0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
    logic        ex_valid, load_use_stall;
    logic [8:0]  ex_ctrl;
    logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
`ifdef ID_EX_PERF_EN
    logic [31:0] bubble_cnt;
`endif

    id_ex_register dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_ctrl(id_ctrl), .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data),
        .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .load_use_stall(load_use_stall)
`ifdef ID_EX_PERF_EN
        , .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          cyc = 0, checks = 0, errors = 0;
    exp_t        q[$];
    logic [31:0] exp_bc = '0;
    localparam logic [8:0] ADD = 9'h10A, LW = 9'h1B0;
    localparam vec_t BUBBLE = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t mk(logic v, logic [8:0] c, logic [31:0] pc, logic [31:0] rsd,
                                logic [31:0] rtd, logic [31:0] imm, logic [4:0] rs,
                                logic [4:0] rt, logic [4:0] rd);
        vec_t x;
        x.v = v; x.c = c; x.pc = pc; x.rsd = rsd; x.rtd = rtd; x.imm = imm;
        x.rs = rs; x.rt = rt; x.rd = rd;
        return x;
    endfunction

    // what EX must hold after loading x: control is gated off for a non-valid slot
    function automatic vec_t ld(vec_t x);
        vec_t y = x;
        if (!x.v) y.c = '0;
        return y;
    endfunction

    task automatic drive(vec_t x);
        id_valid = x.v; id_ctrl = x.c; id_pc4 = x.pc; id_rs_data = x.rsd;
        id_rt_data = x.rtd; id_imm = x.imm; id_rs = x.rs; id_rt = x.rt; id_rd = x.rd;
    endtask

    task automatic push(string n, int due, bit is_lus, logic lus, vec_t e);
        exp_t t;
        t.name = n; t.due = due; t.is_lus = is_lus; t.lus = lus; t.e = e; t.bc = exp_bc;
        q.push_back(t);
    endtask

    task automatic exp_reg(string n, vec_t e); push(n, cyc + 1, 1'b0, 1'b0, e); endtask
    task automatic exp_now(string n, vec_t e); push(n, cyc, 1'b0, 1'b0, e); endtask
    task automatic exp_lus(string n, logic b); push(n, cyc, 1'b1, b, BUBBLE); endtask
    task automatic step(); @(posedge clk); #1; endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t t;
            vec_t a;
            t = q.pop_front();
            a = mk(ex_valid, ex_ctrl, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd);
            checks++;
            if (t.is_lus) begin
                if (load_use_stall !== t.lus) begin
                    errors++;
                    $display("FAIL %s load_use_stall: got %b expected %b", t.name, load_use_stall, t.lus);
                end
            end else begin
                if (a !== t.e) begin
                    errors++;
                    $display("FAIL %s ex regs: got %h expected %h", t.name, a, t.e);
                end
`ifdef ID_EX_PERF_EN
                checks++;
                if (bubble_cnt !== t.bc) begin
                    errors++;
                    $display("FAIL %s bubble_cnt: got %h expected %h", t.name, bubble_cnt, t.bc);
                end
`endif
            end
        end
    end

    vec_t v1, v2, v3, v4, v5, v6, v6s, v7, v8, v9, v10, v11, v12, v13;

    initial begin
        v1  = mk(1, ADD, 32'h8,  32'h11,  32'h22, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd3);
        v2  = mk(1, LW,  32'hC,  32'h100, 32'h0,  32'h4,    5'd1, 5'd5, 5'd0);
        v3  = mk(1, ADD, 32'h10, 32'h55,  32'h66, 32'h0,    5'd5, 5'd6, 5'd7);
        v4  = mk(1, LW,  32'h14, 32'h200, 32'h0,  32'h8,    5'd2, 5'd0, 5'd0);
        v5  = mk(1, ADD, 32'h18, 32'h0,   32'h0,  32'h0,    5'd0, 5'd0, 5'd9);
        v6  = mk(1, ADD, 32'h1C, 32'h33,  32'h34, 32'h5,    5'd3, 5'd4, 5'd8);
        v6s = mk(1, ADD, 32'h20, 32'h44,  32'h45, 32'h1234, 5'd3, 5'd4, 5'd8);
        v7  = mk(1, LW,  32'h24, 32'h77,  32'h0,  32'h10,   5'd1, 5'd9, 5'd0);
        v8  = mk(1, ADD, 32'h28, 32'h88,  32'h89, 32'h0,    5'd2, 5'd9, 5'd10);
        v9  = mk(1, ADD, 32'h2C, 32'h1,   32'h2,  32'h3,    5'd4, 5'd5, 5'd6);
        v10 = mk(1, 9'h1FF, 32'h34, 32'hAB, 32'hAC, 32'hCD, 5'd11, 5'd12, 5'd13);
        v11 = mk(1, ADD, 32'h40, 32'hDE,  32'hAD, 32'hBE,   5'd14, 5'd15, 5'd16);
        v12 = mk(1, LW,  32'h48, 32'hF0,  32'h0,  32'h20,   5'd1, 5'd7, 5'd0);
        v13 = mk(1, ADD, 32'h4C, 32'hF1,  32'hF2, 32'h0,    5'd7, 5'd3, 5'd17);

        step(); step();
        exp_now("reset_state", BUBBLE); exp_lus("reset_lus", 1'b0);
        reset = 1'b0;
        step();

        drive(v1); exp_lus("normal_lus", 1'b0); exp_reg("normal_load", ld(v1)); step();
        drive(v2); exp_lus("lw_lus", 1'b0); exp_reg("lw_load", ld(v2)); step();
        drive(v3); exp_lus("loaduse_hit", 1'b1);
        exp_bc = exp_bc + 1; exp_reg("loaduse_bubble", BUBBLE); step();
        exp_lus("loaduse_release", 1'b0); exp_reg("after_bubble", ld(v3)); step();
        drive(v4); exp_lus("lw_r0_lus", 1'b0); exp_reg("lw_r0_load", ld(v4)); step();
        drive(v5); exp_lus("r0_no_hazard", 1'b0); exp_reg("r0_load", ld(v5)); step();

        drive(v6); exp_lus("pre_stall_lus", 1'b0); exp_reg("pre_stall_load", ld(v6)); step();
        drive(v6s); stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_reg($sformatf("stall_hold%0d", i), ld(v6)); step();
        end
        stall = 1'b0; exp_reg("stall_release", ld(v6s)); step();

        drive(v7); exp_reg("lw2_load", ld(v7)); step();
        drive(v8); stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_lus($sformatf("stall_lu_lus%0d", i), 1'b1);
            exp_reg($sformatf("stall_lu_hold%0d", i), ld(v7)); step();
        end
        stall = 1'b0; exp_lus("stall_lu_drop", 1'b1);
        exp_bc = exp_bc + 1; exp_reg("stall_lu_bubble", BUBBLE); step();
        exp_lus("stall_lu_after", 1'b0); exp_reg("stall_lu_load", ld(v8)); step();

        drive(v9); stall = 1'b1; flush = 1'b1;
        exp_lus("flush_lus", 1'b0); exp_reg("flush_wins", BUBBLE); step();
        stall = 1'b0; flush = 1'b0;
        v9.v = 1'b0; v9.pc = 32'h30; v9.rsd = 32'h99; v9.imm = 32'h7;
        drive(v9); exp_reg("invalid_load", ld(v9)); step();

        drive(v10); exp_lus("allones_lus", 1'b0); exp_reg("allones_load", ld(v10)); step();
        stall = 1'b1; id_valid = 1'b0;
        exp_lus("pre_reset_lus", 1'b0); step();
        reset = 1'b1; #1;
        exp_bc = '0; exp_now("async_reset", BUBBLE); exp_lus("async_reset_lus", 1'b0);
        step();
        reset = 1'b0; stall = 1'b0;
        drive(v11); exp_lus("post_reset_lus", 1'b0); exp_reg("post_reset_load", ld(v11)); step();

`ifdef ID_EX_PERF_EN
        @(negedge clk); #1;
        force dut.r_bubble_cnt = 32'hFFFFFFFF;
        #1;
        release dut.r_bubble_cnt;
        exp_bc = 32'hFFFFFFFF;
        step();
        drive(v12); exp_lus("wrap_lw_lus", 1'b0); exp_reg("wrap_lw_load", ld(v12)); step();
        drive(v13); exp_lus("wrap_hit", 1'b1);
        exp_bc = 32'h0; exp_reg("wrap_bubble", BUBBLE); step();
        exp_reg("wrap_after", ld(v13)); step();
`endif

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            errors += q.size();
            $display("FAIL drain: %0d expectations never checked, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/id_ex_register.md
# id_ex_register

Pipeline register between decode (ID) and execute (EX) in the 5-stage MIPS pipeline. It captures the decoded control bundle, register-file read data, register specifiers, PC+4 and the 32-bit sign-extended immediate from the sign-extension unit. It also contains the load-use hazard detector, which converts a dependent instruction into a bubble. It supports hold (stall) and kill (flush) from pipeline control.

## Interface
Parameters:
- DATA_W, 32, datapath width (PC, register data, extended immediate)
- REG_W, 5, register specifier width

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- stall  in  1  hold: EX register keeps its current contents
- flush  in  1  kill: EX register loads a bubble
- id_valid  in  1  ID holds a real instruction
- id_ctrl  in  9  {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, branch, alu_op[1:0]}, MSB first
- id_pc4  in  DATA_W  PC+4 of the ID instruction
- id_rs_data, id_rt_data  in  DATA_W  register file read data
- id_imm  in  DATA_W  sign-extended immediate (address output of the sign-extension unit)
- id_rs, id_rt, id_rd  in  REG_W  register specifiers
- ex_valid  out  1  registered valid
- ex_ctrl  out  9  registered control bundle
- ex_pc4, ex_rs_data, ex_rt_data, ex_imm  out  DATA_W  registered datapath values
- ex_rs, ex_rt, ex_rd  out  REG_W  registered specifiers
- load_use_stall  out  1  combinational; upstream PC and IF/ID must hold while it is high
- bubble_cnt  out  32  bubbles inserted (present only under ID_EX_PERF_EN)

## Operation
- Hazard detection: load_use_stall = ex_valid & ex_ctrl[mem_read] & (ex_rt != 0) & id_valid & (ex_rt == id_rs | ex_rt == id_rt).
- Next-state priority, evaluated each rising edge:
  - reset: all outputs 0.
  - flush: bubble. ex_valid=0, ex_ctrl=0, datapath fields=0.
  - stall: hold all fields unchanged.
  - load_use_stall: bubble, same as flush.
  - otherwise: load all id_* values; ex_valid=id_valid.
- A bubble forces ex_ctrl to 0, so reg_write, mem_read and mem_write are all deasserted.
- With id_valid=0, ex_valid is 0 and ex_ctrl is forced to 0 on load.
- id_imm is passed through unmodified. No re-extension is done and no width check is applied.
- Register $0 never triggers a hazard.

## Timing
- Latency: 1 cycle, ID to EX, for every field.
- load_use_stall is purely combinational from the current ex_* registers and the id_* inputs. It is high for exactly one cycle per load-use pair: after the bubble, ex_valid=0, so it deasserts.
- stall and flush together: flush wins, and a bubble is loaded.
- stall and load_use_stall together: hold wins. The load stays in EX and load_use_stall stays high until stall drops. Then the bubble is inserted.
- Reset asserted mid-operation: outputs go to 0 immediately, without waiting for a clock edge. After reset deasserts, the first edge loads normally.
- Reset value of every output is 0, including bubble_cnt.

## Configuration
- ID_EX_PERF_EN defined:
  - bubble_cnt is present.
  - It increments by 1 on every edge where a bubble is loaded because of load_use_stall. Flush-caused bubbles are not counted.
  - It does not increment while stall is high.
  - It wraps from 0xFFFFFFFF to 0.
  - It is cleared by reset.
- ID_EX_PERF_EN undefined: the port and counter are absent, and all other behaviour is identical.

## Test plan
- Normal load: id_valid=1, id_imm=0xFFFFFFFC (from immediate -4), id_pc4=0x00000008, no stall/flush. Next edge: ex_imm=0xFFFFFFFC, ex_pc4=0x00000008, ex_valid=1.
- Load-use: EX holds lw with ex_rt=5 and mem_read=1; ID has id_rs=5. Required: load_use_stall=1, next edge ex_valid=0 and ex_ctrl=0, following cycle load_use_stall=0, bubble_cnt=1 (with ID_EX_PERF_EN). Repeat with ex_rt=0: no stall.
- Stall hold: load ex_imm=0x00000005, then assert stall 3 cycles while id_imm=0x1234. Required: ex_imm stays 0x00000005 throughout; 0x00001234 appears on the first edge after stall drops.
- Flush vs stall: assert flush and stall together with ex_valid=1. Next edge: ex_valid=0, ex_ctrl=0.
- Async reset: assert reset between clock edges while ex_valid=1 and ex_ctrl=0x1FF. Required: all outputs 0 before the next edge.
- Counter wrap (ID_EX_PERF_EN): force bubble_cnt=0xFFFFFFFF, trigger one load-use bubble. Required: bubble_cnt=0.
